// File: rtl/ddr3_app_responder.sv
// RAM-backed stand-in for a DDR3 application-interface core: accepts cmd/wr
// channel traffic into a small byte-maskable store and answers reads after a fixed latency.
module ddr3_app_responder #(
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 28,
  parameter int MEM_ABITS    = 6,
  parameter int CALIB_CYCLES = 16,
  parameter int READ_LATENCY = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    init_calib_complete_o,
  output logic                    cmd_ready_o,
  input  logic                    cmd_en_i,
  input  logic [2:0]              cmd_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [5:0]              app_burst_number_i,
  output logic                    wr_data_rdy_o,
  input  logic                    wr_data_en_i,
  input  logic                    wr_data_end_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_data_mask_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    rd_data_valid_o,
  output logic                    rd_data_end_o,
  output logic                    error_o
);

  localparam int CAL_W  = (CALIB_CYCLES > 2) ? $clog2(CALIB_CYCLES) : 1;
  localparam int WAIT_W = (READ_LATENCY > 3) ? $clog2(READ_LATENCY - 1) : 1;
  localparam logic [CAL_W-1:0]  CAL_LAST  = CAL_W'((CALIB_CYCLES > 1) ? CALIB_CYCLES - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((READ_LATENCY > 2) ? READ_LATENCY - 2 : 0);

  typedef enum logic [2:0] {S_CALIB, S_IDLE, S_WRITE, S_RDWAIT, S_READ} state_t;

  state_t                state, state_d;
  logic [CAL_W-1:0]      cal_cnt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [MEM_ABITS-1:0]  idx;
  logic [6:0]            beats_left;
  logic [DATA_WIDTH-1:0] mem [2**MEM_ABITS];

  logic accept, is_wr_cmd, is_rd_cmd, wr_beat, rd_beat, last_beat, error_d;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{addr_i[ADDR_WIDTH-1:MEM_ABITS+3], addr_i[2:0]};

  assign accept    = cmd_ready_o & cmd_en_i;
  assign is_wr_cmd = (cmd_i == 3'b000);
  assign is_rd_cmd = (cmd_i == 3'b001);
  assign wr_beat   = (state == S_WRITE) & wr_data_en_i;
  assign rd_beat   = (state == S_READ);
  assign last_beat = (beats_left == 7'd1);

  always_comb begin
    state_d = state;
    unique case (state)
      S_CALIB:  if (cal_cnt == CAL_LAST) state_d = S_IDLE;
      S_IDLE: begin
        if (accept && is_wr_cmd) state_d = S_WRITE;
        else if (accept && is_rd_cmd) begin
          if (READ_LATENCY > 1) state_d = S_RDWAIT;
          else                  state_d = S_READ;
        end
      end
      S_WRITE:  if (wr_beat && last_beat) state_d = S_IDLE;
      S_RDWAIT: if (wait_cnt == '0) state_d = S_READ;
      S_READ:   if (last_beat) state_d = S_IDLE;
      default:  state_d = S_CALIB;
    endcase
  end

  always_comb begin
    error_d = error_o;
    if (accept && !is_wr_cmd && !is_rd_cmd) error_d = 1'b1;
    if (wr_data_en_i && state != S_WRITE)   error_d = 1'b1;
    if (wr_beat && (wr_data_end_i != last_beat)) error_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                 <= S_CALIB;
      cal_cnt               <= '0;
      wait_cnt              <= '0;
      idx                   <= '0;
      beats_left            <= '0;
      init_calib_complete_o <= 1'b0;
      cmd_ready_o           <= 1'b0;
      wr_data_rdy_o         <= 1'b0;
      rd_data_o             <= '0;
      rd_data_valid_o       <= 1'b0;
      rd_data_end_o         <= 1'b0;
      error_o               <= 1'b0;
    end else begin
      state <= state_d;
      if (state == S_CALIB && cal_cnt != CAL_LAST) cal_cnt <= cal_cnt + CAL_W'(1);

      init_calib_complete_o <= (state_d != S_CALIB);
      // Ready is withheld for one cycle after a read so it trails the final beat.
      cmd_ready_o     <= (state_d == S_IDLE) && !accept && (state != S_READ);
      wr_data_rdy_o   <= (state_d == S_WRITE);
      rd_data_valid_o <= rd_beat;
      rd_data_end_o   <= rd_beat & last_beat;
      error_o         <= error_d;
      if (rd_beat) rd_data_o <= mem[idx];

      if (accept) begin
        idx        <= addr_i[MEM_ABITS+2:3];
        beats_left <= {1'b0, app_burst_number_i} + 7'd1;
        wait_cnt   <= WAIT_LOAD;
      end else if (wr_beat || rd_beat) begin
        idx        <= idx + MEM_ABITS'(1);
        beats_left <= beats_left - 7'd1;
      end else if (state == S_RDWAIT && wait_cnt != '0) begin
        wait_cnt   <= wait_cnt - WAIT_W'(1);
      end
    end
  end

  // Backing store is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_beat) begin
      for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
        if (!wr_data_mask_i[b]) mem[idx][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Randomized bench for ddr3_app_responder against a word-array model of the store.
module tb_ddr3_app_responder;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         init_calib_complete_o, cmd_ready_o, wr_data_rdy_o;
  logic         cmd_en_i = 1'b0;
  logic [2:0]   cmd_i = '0;
  logic [27:0]  addr_i = '0;
  logic [5:0]   app_burst_number_i = '0;
  logic         wr_data_en_i = 1'b0, wr_data_end_i = 1'b0;
  logic [127:0] wr_data_i = '0;
  logic [15:0]  wr_data_mask_i = '0;
  logic [127:0] rd_data_o;
  logic         rd_data_valid_o, rd_data_end_o, error_o;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [127:0] model_mem [64];
  logic [127:0] wdata_q [$];
  logic [15:0]  wmask_q [$];

  ddr3_app_responder #(
    .DATA_WIDTH(128), .ADDR_WIDTH(28), .MEM_ABITS(6), .CALIB_CYCLES(16), .READ_LATENCY(4)
  ) dut (
    .clock(clock), .reset(reset),
    .init_calib_complete_o(init_calib_complete_o), .cmd_ready_o(cmd_ready_o),
    .cmd_en_i(cmd_en_i), .cmd_i(cmd_i), .addr_i(addr_i), .app_burst_number_i(app_burst_number_i),
    .wr_data_rdy_o(wr_data_rdy_o), .wr_data_en_i(wr_data_en_i), .wr_data_end_i(wr_data_end_i),
    .wr_data_i(wr_data_i), .wr_data_mask_i(wr_data_mask_i),
    .rd_data_o(rd_data_o), .rd_data_valid_o(rd_data_valid_o), .rd_data_end_o(rd_data_end_o),
    .error_o(error_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [133:0] all_outputs();
    return {init_calib_complete_o, cmd_ready_o, wr_data_rdy_o, rd_data_valid_o,
            rd_data_end_o, error_o, rd_data_o};
  endfunction

  // Asserts reset between edges, then expects ready exactly 16 clocks after release.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_outputs", 256'(all_outputs()), '0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      check($sformatf("calib_%0d", k), {init_calib_complete_o, cmd_ready_o},
            (k == 16) ? 2'b11 : 2'b00);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready_o && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready_o) check("ready_timeout", cmd_ready_o, 1'b1);
  endtask

  task automatic issue_cmd(input logic [2:0] c, input logic [27:0] a, input logic [5:0] b);
    wait_ready();
    cmd_en_i = 1'b1; cmd_i = c; addr_i = a; app_burst_number_i = b;
    @(negedge clock);
    cmd_en_i = 1'b0;
    check("cmd_ready_drop", cmd_ready_o, 1'b0);
  endtask

  task automatic write_burst(input logic [27:0] a, input logic [5:0] b, input logic early_end);
    logic [5:0]   w;
    int           n, i, guard;
    logic [127:0] d;
    logic [15:0]  m;
    w = a[8:3];
    n = int'(b) + 1;
    issue_cmd(3'b000, a, b);
    check("wr_rdy_rise", wr_data_rdy_o, 1'b1);
    i = 0; guard = 0;
    while (i < n && guard < 1000) begin
      if (wdata_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        wr_data_en_i = 1'b0;
      end else begin
        if (wdata_q.size() > 0) begin
          d = wdata_q.pop_front();
          m = wmask_q.pop_front();
        end else begin
          d = {$urandom, $urandom, $urandom, $urandom};
          m = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
        end
        wr_data_en_i = 1'b1; wr_data_i = d; wr_data_mask_i = m;
        wr_data_end_i = (i == n - 1) || early_end;
        for (int bb = 0; bb < 16; bb++)
          if (!m[bb]) model_mem[w][bb*8 +: 8] = d[bb*8 +: 8];
        w = w + 6'd1;
        i++;
      end
      @(negedge clock);
      guard++;
    end
    wr_data_en_i = 1'b0; wr_data_end_i = 1'b0;
    check("wr_rdy_drop", wr_data_rdy_o, 1'b0);
  endtask

  task automatic read_burst(input logic [27:0] a, input logic [5:0] b);
    logic [5:0]   w;
    int           n, lat;
    logic [127:0] last;
    w = a[8:3];
    n = int'(b) + 1;
    issue_cmd(3'b001, a, b);
    lat = 0;
    while (!rd_data_valid_o && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("rd_latency", lat, 4);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clock);
      check($sformatf("rd_valid_w%0d", w), rd_data_valid_o, 1'b1);
      check($sformatf("rd_data_w%0d", w), rd_data_o, model_mem[w]);
      check("rd_end", rd_data_end_o, (i == n - 1));
      w = w + 6'd1;
    end
    last = rd_data_o;
    @(negedge clock);
    check("rd_valid_after", rd_data_valid_o, 1'b0);
    check("rd_data_hold", rd_data_o, last);
    check("ready_after_read", cmd_ready_o, 1'b1);
  endtask

  initial begin
    logic [27:0] a;
    logic [5:0]  b;
    int          n;

    do_reset();

    // Bring every word to a known value first.
    for (int i = 0; i < 64; i++) begin
      wdata_q.push_back({$urandom, $urandom, $urandom, $urandom});
      wmask_q.push_back(16'h0000);
    end
    write_burst(28'h0, 6'd63, 1'b0);

    wdata_q.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
    wmask_q.push_back(16'h0000);
    write_burst(28'h10, 6'd0, 1'b0);
    read_burst(28'h10, 6'd0);
    check("single_beat_const", model_mem[2], 128'h00112233_44556677_8899AABB_CCDDEEFF);

    wdata_q.push_back(128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004);
    wmask_q.push_back(16'h0000);
    wdata_q.push_back(128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004);
    wmask_q.push_back(16'h0000);
    write_burst(28'h1F8, 6'd1, 1'b0);
    read_burst(28'h1F8, 6'd0);
    read_burst(28'h000, 6'd0);

    wdata_q.push_back('0);
    wmask_q.push_back(16'h0000);
    write_burst(28'h10, 6'd0, 1'b0);
    wdata_q.push_back('1);
    wmask_q.push_back(16'hFFFE);
    write_burst(28'h10, 6'd0, 1'b0);
    read_burst(28'h10, 6'd0);

    read_burst(28'h40, 6'd7);

    for (int op = 0; op < 40; op++) begin
      a = 28'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) write_burst(a, b, 1'b0);
      else                           read_burst(a, b);
    end
    check("no_spurious_error", error_o, 1'b0);

    issue_cmd(3'b010, 28'h0, 6'd0);
    check("err_bad_cmd", error_o, 1'b1);
    repeat (5) @(negedge clock);
    check("err_sticky", error_o, 1'b1);
    read_burst(28'h8, 6'd0);
    check("err_sticky_read", error_o, 1'b1);

    do_reset();
    read_burst(28'h28, 6'd0);
    wait_ready();
    wr_data_en_i = 1'b1; wr_data_end_i = 1'b1; wr_data_i = '1; wr_data_mask_i = '0;
    @(negedge clock);
    wr_data_en_i = 1'b0; wr_data_end_i = 1'b0;
    check("err_stray_wr", error_o, 1'b1);
    read_burst(28'h30, 6'd0);
    read_burst(28'h28, 6'd1);

    do_reset();
    write_burst(28'h100, 6'd1, 1'b1);
    check("err_early_end", error_o, 1'b1);
    read_burst(28'h100, 6'd1);

    issue_cmd(3'b001, 28'h0, 6'd63);
    n = 0;
    while (!rd_data_valid_o && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("mid_read_started", rd_data_valid_o, 1'b1);
    repeat (3) @(negedge clock);
    do_reset();
    read_burst(28'h0, 6'd3);
    read_burst(28'h100, 6'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
